// File: rtl/memory_access_if.sv
// Memory-controller bus between the MEM stage (master) and the memory controller (slave).
interface memory_access_if;
    logic        mem_mc_en;
    logic        mem_mc_rw;
    logic [31:0] mem_mc_addr;
    logic [3:0]  mem_mc_be;
    logic [31:0] mem_mc_wdata;
    logic [31:0] mc_mem_rdata;
    logic        mc_mem_ready;

    modport master (
        output mem_mc_en, mem_mc_rw, mem_mc_addr, mem_mc_be, mem_mc_wdata,
        input  mc_mem_rdata, mc_mem_ready
    );

    modport slave (
        input  mem_mc_en, mem_mc_rw, mem_mc_addr, mem_mc_be, mem_mc_wdata,
        output mc_mem_rdata, mc_mem_ready
    );
endinterface

// File: rtl/memory_access.sv
// MEM stage: issues load/store bus cycles, stalls the pipeline until completion, formats load data.
// Define MEM_ACCESS_TIMEOUT_EN to abandon a bus cycle after 16 cycles without ready.
//   state  | meaning
//   IDLE   | results pass through; a new access starts the bus cycle combinationally
//   ACCESS | bus cycle outstanding, pipeline stalled, write-back bubbled
module memory_access (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_mem_readmem,
    input  logic        ex_mem_writemem,
    input  logic        ex_mem_mshw,
    input  logic        ex_mem_lshw,
    input  logic        ex_mem_writereg,
    input  logic [2:0]  ex_mem_msm,
    input  logic [2:0]  ex_mem_msl,
    input  logic [31:0] ex_mem_aluout,
    input  logic [31:0] ex_mem_regb,
    input  logic [31:0] ex_mem_wbvalue,
    input  logic [2:0]  ex_mem_selwsource,
    input  logic [4:0]  ex_mem_regdest,
    memory_access_if.master bus,
    output logic        mem_if_stall,
    output logic        mem_misalign,
    output logic        mem_timeout,
    output logic [4:0]  mem_wb_regdest,
    output logic        mem_wb_writereg,
    output logic [31:0] mem_wb_wbvalue,
    output logic        mem_fw_writereg,
    output logic [31:0] mem_fw_wbvalue
);

    typedef enum logic {IDLE, ACCESS} state_t;
    state_t state;

    logic        access, is_byte, is_half, is_word, misalign, start;
    logic [3:0]  store_be;
    logic [31:0] store_wdata;

    logic [31:0] lat_addr, lat_wdata, lat_regb, lat_wbvalue;
    logic [3:0]  lat_be;
    logic [2:0]  lat_msl, lat_sel;
    logic [1:0]  lat_off;
    logic [4:0]  lat_regdest;
    logic        lat_rw, lat_mshw, lat_lshw, lat_writereg;
    logic [31:0] load_value;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // A simultaneous read and write request is treated as a write, so store sizing wins.
    always_comb begin
        access  = ex_mem_readmem | ex_mem_writemem;
        is_byte = 1'b0;
        is_half = 1'b0;
        if (ex_mem_writemem) begin
            is_byte = (ex_mem_msm == 3'b001);
            is_half = (ex_mem_msm == 3'b010);
        end else begin
            is_byte = (ex_mem_msl == 3'b001) || (ex_mem_msl == 3'b010);
            is_half = (ex_mem_msl == 3'b011) || (ex_mem_msl == 3'b100);
        end
        is_word  = !is_byte && !is_half;
        misalign = access && ((is_half && ex_mem_aluout[0]) ||
                              (is_word && (ex_mem_aluout[1:0] != 2'b00)));
        start    = access && !misalign;
    end

    always_comb begin
        store_be    = 4'b1111;
        store_wdata = 32'h0;
        if (ex_mem_writemem) begin
            if (is_byte) begin
                store_be    = 4'b0001 << ex_mem_aluout[1:0];
                store_wdata = {4{ex_mem_regb[7:0]}};
            end else if (is_half) begin
                store_be    = ex_mem_aluout[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{ex_mem_regb[15:0]}};
            end else begin
                store_wdata = ex_mem_regb;
            end
        end
    end

    always_comb begin
        case (lat_off)
            2'b00:   load_byte = bus.mc_mem_rdata[7:0];
            2'b01:   load_byte = bus.mc_mem_rdata[15:8];
            2'b10:   load_byte = bus.mc_mem_rdata[23:16];
            default: load_byte = bus.mc_mem_rdata[31:24];
        endcase
        load_half = lat_off[1] ? bus.mc_mem_rdata[31:16] : bus.mc_mem_rdata[15:0];
        case (lat_msl)
            3'b001:  load_value = {{24{load_byte[7]}}, load_byte};
            3'b010:  load_value = {24'h0, load_byte};
            3'b011:  load_value = {{16{load_half[15]}}, load_half};
            3'b100:  load_value = {16'h0, load_half};
            default: begin
                if (lat_mshw && !lat_lshw)
                    load_value = {bus.mc_mem_rdata[31:16], lat_regb[15:0]};
                else if (lat_lshw && !lat_mshw)
                    load_value = {lat_regb[31:16], bus.mc_mem_rdata[15:0]};
                else
                    load_value = bus.mc_mem_rdata;
            end
        endcase
    end

    // Bus and stall are combinational so the access starts in the same cycle; reset masks them.
    always_comb begin
        bus.mem_mc_en    = 1'b0;
        bus.mem_mc_rw    = 1'b0;
        bus.mem_mc_addr  = 32'h0;
        bus.mem_mc_be    = 4'h0;
        bus.mem_mc_wdata = 32'h0;
        mem_if_stall     = 1'b0;
        if (!reset) begin
            if (state == ACCESS) begin
                bus.mem_mc_en    = 1'b1;
                bus.mem_mc_rw    = lat_rw;
                bus.mem_mc_addr  = lat_addr;
                bus.mem_mc_be    = lat_be;
                bus.mem_mc_wdata = lat_wdata;
                mem_if_stall     = !bus.mc_mem_ready;
            end else if (start) begin
                bus.mem_mc_en    = 1'b1;
                bus.mem_mc_rw    = ex_mem_writemem;
                bus.mem_mc_addr  = {ex_mem_aluout[31:2], 2'b00};
                bus.mem_mc_be    = store_be;
                bus.mem_mc_wdata = store_wdata;
                mem_if_stall     = 1'b1;
            end
        end
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic [3:0] tmo_cnt;
    logic       timeout_q;
    assign mem_timeout = timeout_q;
`else
    assign mem_timeout = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            mem_misalign    <= 1'b0;
            mem_wb_regdest  <= 5'h0;
            mem_wb_writereg <= 1'b0;
            mem_wb_wbvalue  <= 32'h0;
            lat_addr        <= 32'h0;
            lat_wdata       <= 32'h0;
            lat_regb        <= 32'h0;
            lat_wbvalue     <= 32'h0;
            lat_be          <= 4'h0;
            lat_msl         <= 3'h0;
            lat_sel         <= 3'h0;
            lat_off         <= 2'h0;
            lat_regdest     <= 5'h0;
            lat_rw          <= 1'b0;
            lat_mshw        <= 1'b0;
            lat_lshw        <= 1'b0;
            lat_writereg    <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            tmo_cnt         <= 4'h0;
            timeout_q       <= 1'b0;
`endif
        end else begin
`ifdef MEM_ACCESS_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        state           <= ACCESS;
                        mem_misalign    <= 1'b0;
                        mem_wb_writereg <= 1'b0;
                        lat_addr        <= {ex_mem_aluout[31:2], 2'b00};
                        lat_rw          <= ex_mem_writemem;
                        lat_be          <= store_be;
                        lat_wdata       <= store_wdata;
                        lat_off         <= ex_mem_aluout[1:0];
                        lat_msl         <= ex_mem_msl;
                        lat_mshw        <= ex_mem_mshw;
                        lat_lshw        <= ex_mem_lshw;
                        lat_regb        <= ex_mem_regb;
                        lat_sel         <= ex_mem_selwsource;
                        lat_wbvalue     <= ex_mem_wbvalue;
                        lat_regdest     <= ex_mem_regdest;
                        lat_writereg    <= ex_mem_writereg;
`ifdef MEM_ACCESS_TIMEOUT_EN
                        tmo_cnt         <= 4'hF;
`endif
                    end else begin
                        mem_misalign    <= misalign;
                        mem_wb_regdest  <= ex_mem_regdest;
                        mem_wb_writereg <= ex_mem_writereg && !misalign;
                        mem_wb_wbvalue  <= ex_mem_wbvalue;
                    end
                end
                ACCESS: begin
                    mem_misalign <= 1'b0;
                    if (bus.mc_mem_ready) begin
                        state           <= IDLE;
                        mem_wb_regdest  <= lat_regdest;
                        mem_wb_writereg <= lat_writereg;
                        mem_wb_wbvalue  <= (!lat_rw && lat_sel == 3'b001) ? load_value : lat_wbvalue;
                    end
`ifdef MEM_ACCESS_TIMEOUT_EN
                    else if (tmo_cnt == 4'h0) begin
                        state           <= IDLE;
                        timeout_q       <= 1'b1;
                        mem_wb_writereg <= 1'b0;
                    end else begin
                        mem_wb_writereg <= 1'b0;
                        tmo_cnt         <= tmo_cnt - 4'h1;
                    end
`else
                    else begin
                        mem_wb_writereg <= 1'b0;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_fw_writereg = mem_wb_writereg;
    assign mem_fw_wbvalue  = mem_wb_wbvalue;

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: stimulus pushes expected bus cycles and write-back results.
module tb_memory_access;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ex_mem_readmem, ex_mem_writemem, ex_mem_mshw, ex_mem_lshw, ex_mem_writereg;
    logic [2:0]  ex_mem_msm, ex_mem_msl, ex_mem_selwsource;
    logic [31:0] ex_mem_aluout, ex_mem_regb, ex_mem_wbvalue;
    logic [4:0]  ex_mem_regdest;
    logic        mem_if_stall, mem_misalign, mem_timeout;
    logic [4:0]  mem_wb_regdest;
    logic        mem_wb_writereg, mem_fw_writereg;
    logic [31:0] mem_wb_wbvalue, mem_fw_wbvalue;

    memory_access_if bus ();

    memory_access dut (
        .clock(clock), .reset(reset),
        .ex_mem_readmem(ex_mem_readmem), .ex_mem_writemem(ex_mem_writemem),
        .ex_mem_mshw(ex_mem_mshw), .ex_mem_lshw(ex_mem_lshw), .ex_mem_writereg(ex_mem_writereg),
        .ex_mem_msm(ex_mem_msm), .ex_mem_msl(ex_mem_msl),
        .ex_mem_aluout(ex_mem_aluout), .ex_mem_regb(ex_mem_regb), .ex_mem_wbvalue(ex_mem_wbvalue),
        .ex_mem_selwsource(ex_mem_selwsource), .ex_mem_regdest(ex_mem_regdest),
        .bus(bus),
        .mem_if_stall(mem_if_stall), .mem_misalign(mem_misalign), .mem_timeout(mem_timeout),
        .mem_wb_regdest(mem_wb_regdest), .mem_wb_writereg(mem_wb_writereg),
        .mem_wb_wbvalue(mem_wb_wbvalue), .mem_fw_writereg(mem_fw_writereg),
        .mem_fw_wbvalue(mem_fw_wbvalue)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  regdest;
        logic        writereg;
        logic [31:0] wbvalue;
        logic        misalign;
    } res_t;

    typedef struct {
        logic [31:0] addr;
        logic        rw;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    res_t exp_q[$];
    bus_t bus_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one result per non-stalled cycle, one bus record per new bus cycle.
    logic pend = 1'b0, prev_stall = 1'b0, prev_en = 1'b0, prev_ready = 1'b0;
    bus_t hold;
    always @(negedge clock) begin
        if (!done) begin
            if (pend) begin
                if (exp_q.size() == 0) begin
                    chk("result_unexpected", 32'd1, 32'd0);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    chk("wb_regdest", {27'h0, mem_wb_regdest}, {27'h0, e.regdest});
                    chk("wb_writereg", {31'h0, mem_wb_writereg}, {31'h0, e.writereg});
                    chk("wb_wbvalue", mem_wb_wbvalue, e.wbvalue);
                    chk("misalign", {31'h0, mem_misalign}, {31'h0, e.misalign});
                    chk("fw_writereg", {31'h0, mem_fw_writereg}, {31'h0, e.writereg});
                    chk("fw_wbvalue", mem_fw_wbvalue, e.wbvalue);
                    chk("timeout_idle", {31'h0, mem_timeout}, 32'd0);
                end
            end
            if (prev_stall && !reset)
                chk("bubble_writereg", {31'h0, mem_wb_writereg}, 32'd0);
            if (bus.mem_mc_en) begin
                if (!(prev_en && !prev_ready)) begin
                    if (bus_q.size() == 0) begin
                        chk("bus_unexpected", 32'd1, 32'd0);
                        hold = '{bus.mem_mc_addr, bus.mem_mc_rw, bus.mem_mc_be, bus.mem_mc_wdata};
                    end else begin
                        hold = bus_q.pop_front();
                    end
                end
                chk("bus_addr", bus.mem_mc_addr, hold.addr);
                chk("bus_rw", {31'h0, bus.mem_mc_rw}, {31'h0, hold.rw});
                chk("bus_be", {28'h0, bus.mem_mc_be}, {28'h0, hold.be});
                chk("bus_wdata", bus.mem_mc_wdata, hold.wdata);
            end
            pend       = !reset && !mem_if_stall;
            prev_stall = !reset && mem_if_stall;
            prev_en    = bus.mem_mc_en;
            prev_ready = bus.mc_mem_ready;
        end
    end

    task automatic drive(input logic rd, wr, input logic [2:0] msm, msl,
                         input logic mshw, lshw, wreg, input logic [2:0] sel,
                         input logic [4:0] rdest, input logic [31:0] alu, regb, wbv);
        ex_mem_readmem = rd;   ex_mem_writemem = wr;
        ex_mem_msm = msm;      ex_mem_msl = msl;
        ex_mem_mshw = mshw;    ex_mem_lshw = lshw;
        ex_mem_writereg = wreg; ex_mem_selwsource = sel;
        ex_mem_regdest = rdest; ex_mem_aluout = alu;
        ex_mem_regb = regb;    ex_mem_wbvalue = wbv;
    endtask

    task automatic run_nop(input logic [4:0] rdest, input logic wreg,
                           input logic [31:0] wbv, input logic rdy);
        exp_q.push_back('{rdest, wreg, wbv, 1'b0});
        drive(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, wreg, 3'b001, rdest, 32'h0000_0101, 32'h0, wbv);
        bus.mc_mem_ready = rdy;
        @(posedge clock); #1;
        bus.mc_mem_ready = 1'b0;
    endtask

    task automatic run_mis(input logic rd, wr, input logic [2:0] msm, msl,
                           input logic [4:0] rdest, input logic [31:0] alu, wbv);
        exp_q.push_back('{rdest, 1'b0, wbv, 1'b1});
        drive(rd, wr, msm, msl, 1'b0, 1'b0, 1'b1, 3'b001, rdest, alu, 32'h5555_5555, wbv);
        @(posedge clock); #1;
    endtask

    task automatic run_acc(input logic rd, wr, input logic [2:0] msm, msl,
                           input logic mshw, lshw, wreg, input logic [2:0] sel,
                           input logic [4:0] rdest, input logic [31:0] alu, regb, wbv,
                           input int dly, input logic [31:0] rdata,
                           input logic [31:0] e_addr, input logic [3:0] e_be,
                           input logic [31:0] e_wdata, input logic [31:0] e_wb);
        bus_q.push_back('{e_addr, wr, e_be, e_wdata});
        exp_q.push_back('{rdest, wreg, e_wb, 1'b0});
        drive(rd, wr, msm, msl, mshw, lshw, wreg, sel, rdest, alu, regb, wbv);
        for (int k = 1; k <= dly; k++) begin
            @(posedge clock); #1;
            bus.mc_mem_rdata = rdata;
            bus.mc_mem_ready = (k == dly);
        end
        @(posedge clock); #1;
        bus.mc_mem_ready = 1'b0;
        bus.mc_mem_rdata = 32'hDEAD_0000;
    endtask

    initial begin
        bus.mc_mem_ready = 1'b0;
        bus.mc_mem_rdata = 32'h0;
        // Access request held during reset must not leak onto the bus or stall.
        drive(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 3'b001, 5'd9, 32'h100, 32'h1, 32'h7);
        @(posedge clock); #1;
        chk("rst_stall", {31'h0, mem_if_stall}, 32'd0);
        chk("rst_mc_en", {31'h0, bus.mem_mc_en}, 32'd0);
        chk("rst_wb_writereg", {31'h0, mem_wb_writereg}, 32'd0);
        chk("rst_wb_wbvalue", mem_wb_wbvalue, 32'd0);
        chk("rst_timeout", {31'h0, mem_timeout}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        run_nop(5'd3, 1'b1, 32'd6, 1'b0);
        // store byte at 0x102, ready on the 3rd waiting cycle
        run_acc(1'b0, 1'b1, 3'b001, 3'b000, 1'b0, 1'b0, 1'b1, 3'b000, 5'd4, 32'h102, 32'hAB, 32'h11,
                3, 32'h0, 32'h100, 4'b0100, 32'hABAB_ABAB, 32'h11);
        run_acc(1'b1, 1'b0, 3'b000, 3'b001, 1'b0, 1'b0, 1'b1, 3'b001, 5'd5, 32'h101, 32'h0, 32'h22,
                1, 32'h0000_8000, 32'h100, 4'b1111, 32'h0, 32'hFFFF_FF80);
        run_mis(1'b1, 1'b0, 3'b000, 3'b011, 5'd6, 32'h103, 32'h33);
        run_nop(5'd7, 1'b1, 32'h44, 1'b1);
        run_acc(1'b0, 1'b1, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 5'd8, 32'h206, 32'h1234_5678, 32'h55,
                2, 32'h0, 32'h204, 4'b1100, 32'h5678_5678, 32'h55);
        run_acc(1'b1, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 3'b001, 5'd9, 32'h300, 32'hDEAD_BEEF, 32'h66,
                1, 32'hFFFF_0000, 32'h300, 4'b1111, 32'hDEAD_BEEF, 32'h66);
        run_acc(1'b1, 1'b0, 3'b000, 3'b100, 1'b0, 1'b0, 1'b1, 3'b001, 5'd10, 32'h102, 32'h0, 32'h0,
                2, 32'h8765_4321, 32'h100, 4'b1111, 32'h0, 32'h0000_8765);
        run_acc(1'b1, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0, 1'b1, 3'b001, 5'd11, 32'h103, 32'h0, 32'h0,
                1, 32'h9A00_0000, 32'h100, 4'b1111, 32'h0, 32'h0000_009A);
        run_acc(1'b1, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1, 3'b001, 5'd12, 32'h400, 32'h1111_2222, 32'h0,
                1, 32'hAAAA_BBBB, 32'h400, 4'b1111, 32'h0, 32'hAAAA_2222);
        run_acc(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 3'b001, 5'd13, 32'h400, 32'h1111_2222, 32'h0,
                1, 32'hAAAA_BBBB, 32'h400, 4'b1111, 32'h0, 32'h1111_BBBB);
        run_acc(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 3'b000, 5'd14, 32'h400, 32'h0, 32'h77,
                1, 32'h1234_5678, 32'h400, 4'b1111, 32'h0, 32'h77);
        run_mis(1'b0, 1'b1, 3'b000, 3'b000, 5'd15, 32'h502, 32'h88);
        run_acc(1'b1, 1'b0, 3'b000, 3'b011, 1'b0, 1'b0, 1'b1, 3'b001, 5'd16, 32'h100, 32'h0, 32'h0,
                1, 32'h0000_F00F, 32'h100, 4'b1111, 32'h0, 32'hFFFF_F00F);

        // reset in the middle of an outstanding read
        bus_q.push_back('{32'h600, 1'b0, 4'b1111, 32'h0});
        drive(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 3'b001, 5'd18, 32'h600, 32'h0, 32'h0);
        @(posedge clock); #1;
        @(posedge clock); #2;
        reset = 1'b1;
        #1;
        chk("midrst_stall", {31'h0, mem_if_stall}, 32'd0);
        chk("midrst_mc_en", {31'h0, bus.mem_mc_en}, 32'd0);
        chk("midrst_addr", bus.mem_mc_addr, 32'd0);
        chk("midrst_wb_regdest", {27'h0, mem_wb_regdest}, 32'd0);
        chk("midrst_wb_wbvalue", mem_wb_wbvalue, 32'd0);
        chk("midrst_fw_wbvalue", mem_fw_wbvalue, 32'd0);
        drive(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        run_nop(5'd17, 1'b1, 32'hABCD, 1'b0);

`ifdef MEM_ACCESS_TIMEOUT_EN
        bus_q.push_back('{32'h700, 1'b0, 4'b1111, 32'h0});
        drive(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 3'b001, 5'd20, 32'h700, 32'h0, 32'h0);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clock); #1;
        end
        chk("tmo_last_wait_stall", {31'h0, mem_if_stall}, 32'd1);
        chk("tmo_not_yet", {31'h0, mem_timeout}, 32'd0);
        exp_q.push_back('{5'd21, 1'b1, 32'h99, 1'b0});
        drive(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 3'b001, 5'd21, 32'h0, 32'h0, 32'h99);
        @(posedge clock); #1;
        chk("tmo_pulse", {31'h0, mem_timeout}, 32'd1);
        chk("tmo_stall", {31'h0, mem_if_stall}, 32'd0);
        chk("tmo_writereg", {31'h0, mem_wb_writereg}, 32'd0);
        @(posedge clock); #1;
        chk("tmo_one_cycle", {31'h0, mem_timeout}, 32'd0);
`endif

        run_nop(5'd31, 1'b1, 32'h1234_0000, 1'b0);
        @(negedge clock);
        @(posedge clock);
        done = 1'b1;
        chk("queues_drained", exp_q.size() + bus_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 SHALL have: clock  in  1  single pipeline clock, rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high; one clock, reset asynchronous active-high.
REQ-003 SHALL have: ex_mem_readmem, ex_mem_writemem, ex_mem_mshw, ex_mem_lshw, ex_mem_writereg  in  1 each  EX/MEM control.
REQ-004 SHALL have: ex_mem_msm  in  3  store size (000 word, 001 byte, 010 half; else word).
REQ-005 SHALL have: ex_mem_msl  in  3  load size (000 word, 001 byte-s, 010 byte-u, 011 half-s, 100 half-u; else word).
REQ-006 SHALL have: ex_mem_aluout, ex_mem_regb, ex_mem_wbvalue  in  32 each  address, store data, non-load result.
REQ-007 SHALL have: ex_mem_selwsource  in  3 (001 = loaded data, else ex_mem_wbvalue); ex_mem_regdest  in  5.
REQ-008 SHALL have: mem_mc_en, mem_mc_rw (1 = write)  out  1; mem_mc_addr  out  32 ({aluout[31:2],2'b00}); mem_mc_be  out  4; mem_mc_wdata  out  32.
REQ-009 SHALL have: mc_mem_rdata  in  32; mc_mem_ready  in  1  one-cycle completion strobe.
REQ-010 SHALL have: mem_if_stall  out  1; mem_misalign  out  1; mem_timeout  out  1.
REQ-011 SHALL have: mem_wb_regdest  out  5; mem_wb_writereg  out  1; mem_wb_wbvalue  out  32; mem_fw_writereg  out  1; mem_fw_wbvalue  out  32.

Function
REQ-012 SHALL implement FSM IDLE, ACCESS; reset state IDLE.
REQ-013 No access (readmem=writemem=0): mem_wb_* and mem_fw_* SHALL register inputs at next edge (latency 1), mem_if_stall=0.
REQ-014 Access in IDLE SHALL combinationally raise mem_if_stall, drive mem_mc_en=1, addr, rw, be, wdata, and go to ACCESS at next edge.
REQ-015 readmem=writemem=1 SHALL be a write only.
REQ-016 In ACCESS, mem_mc_en and mem_if_stall SHALL stay 1 and bus outputs stable until mc_mem_ready=1; mem_wb_writereg SHALL be 0 (bubble) each waiting cycle.
REQ-017 On the ready edge: FSM->IDLE, mem_if_stall drops combinationally that cycle, mem_wb_* load result; ready in IDLE SHALL be ignored.
REQ-018 Store be: word 1111; half 0011 (addr[1]=0) / 1100; byte one-hot at addr[1:0] (00->0001); wdata = regb replicated into selected lanes.
REQ-019 Load extract by addr[1:0], sign/zero extend per msl; word load with mshw=1 -> {rdata[31:16],regb[15:0]}, lshw=1 -> {regb[31:16],rdata[15:0]}; both set -> full word.
REQ-020 Loaded value SHALL reach mem_wb_wbvalue only when selwsource=001; writes SHALL leave mem_wb_writereg = ex_mem_writereg.
REQ-021 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no bus cycle, no stall, mem_misalign=1 for one cycle, mem_wb_writereg=0.
REQ-022 mem_fw_wbvalue/mem_fw_writereg SHALL equal mem_wb_wbvalue/mem_wb_writereg.

Reset
REQ-023 Reset SHALL force IDLE and all outputs to 0 immediately, including mid-ACCESS (mem_mc_en drops without awaiting ready).
REQ-024 After reset release, first edge SHALL sample ex_mem_* normally.

Configuration
REQ-025 Macro MEM_ACCESS_TIMEOUT_EN defined: 4-bit counter in ACCESS; 16 cycles without ready -> IDLE, mem_timeout=1 one cycle, mem_wb_writereg=0, stall released.
REQ-026 Macro undefined: no counter, ACCESS waits indefinitely, mem_timeout tied 0.

Verification
REQ-027 Reset asserted mid-ACCESS -> all outputs 0 same cycle, FSM IDLE, mem_mc_en=0.
REQ-028 readmem=writemem=0, wbvalue=6, writereg=1, regdest=3 -> next edge mem_wb_wbvalue=6, writereg=1, regdest=3, stall 0.
REQ-029 Store byte msm=001, aluout=0x102, regb=0xAB -> be=0100, wdata=0xABABABAB, stall until ready after 3 cycles, 3 bubbles.
REQ-030 Load msl=001, selwsource=001, aluout=0x101, rdata=0x0000_8000 on ready -> mem_wb_wbvalue=0xFFFFFF80.
REQ-031 Load half msl=011, aluout=0x103 -> mem_misalign=1 one cycle, mem_mc_en never 1, mem_wb_writereg=0.
REQ-032 With MEM_ACCESS_TIMEOUT_EN, read, ready never asserted -> mem_timeout pulse after 16 ACCESS cycles, stall 0 next cycle.
